// File: rtl/mainmem_responder.sv
// mainmem_responder
// Main-memory side of the cache/main-memory interface. Accepts one single-word
// read or write at a time, holds mainmem_busy high for a fixed latency, then
// completes the access against a word-addressed internal array.
//
// Ports
//   clk             memory clock
//   rst             synchronous reset, active-low
//   mainmem_access  request strobe from the cache, held until completion is seen
//   re, we          read / write qualifiers (write wins when both are set)
//   addr            byte address; word index = addr[ADDR_W+1:2]
//   reg_data        write data
//   mainmem_busy    high while a request is in service
//   dram_data       last read data, updated when a read completes
//   mainmem_done    one-cycle pulse on the cycle busy falls
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for access with re or we set
// SERVE | request latched, latency counter running down to zero
// DONE  | request completed, waiting for access to drop before re-arming

module mainmem_responder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned READ_LAT  = 6,
   parameter int unsigned WRITE_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mainmem_access,
   input  logic        re,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] reg_data,
   output logic        mainmem_busy,
   output logic [31:0] dram_data,
   output logic        mainmem_done
);

   localparam logic [15:0] RD_LOAD = 16'(READ_LAT - 1);
   localparam logic [15:0] WR_LOAD = 16'(WRITE_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                op_we_q, op_we_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         dram_q, dram_d;
   logic                mem_we;

   logic [31:0]         mem [2**ADDR_W];

   // Byte-lane bits and bits above the array depth are intentionally ignored,
   // which makes addresses alias modulo the array size.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      op_we_d = op_we_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      dram_d  = dram_q;
      mem_we  = 1'b0;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (mainmem_access && (re || we)) begin
               op_we_d = we;
               idx_d   = addr[ADDR_W+1:2];
               wdata_d = reg_data;
               cnt_d   = we ? WR_LOAD : RD_LOAD;
               busy_d  = 1'b1;
               state_d = SERVE;
            end
         end
         SERVE: begin
            if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
               if (op_we_q) begin
                  mem_we = 1'b1;
               end else begin
                  dram_d = mem[idx_q];
               end
            end
         end
         DONE: begin
            busy_d = 1'b0;
            if (!mainmem_access) begin
               state_d = IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_we_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         dram_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         op_we_q <= op_we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         dram_q  <= dram_d;
      end
   end

   // Array is never cleared; reset only suppresses a write that has not
   // committed yet.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign mainmem_busy = busy_q;
   assign mainmem_done = done_q;
   assign dram_data    = dram_q;

endmodule

// File: tb/tb_mainmem_responder.sv
module tb_mainmem_responder;

   localparam int ADDR_W    = 10;
   localparam int READ_LAT  = 6;
   localparam int WRITE_LAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mainmem_access;
   logic        re;
   logic        we;
   logic [31:0] addr;
   logic [31:0] reg_data;
   logic        mainmem_busy;
   logic [31:0] dram_data;
   logic        mainmem_done;

   int checks = 0;
   int errors = 0;

   // Reference model: word array keyed by index, plus the last completed read.
   logic [31:0] mem_m [int];
   logic [31:0] last_rd;

   mainmem_responder #(
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT),
      .WRITE_LAT(WRITE_LAT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mainmem_access(mainmem_access),
      .re            (re),
      .we            (we),
      .addr          (addr),
      .reg_data      (reg_data),
      .mainmem_busy  (mainmem_busy),
      .dram_data     (dram_data),
      .mainmem_done  (mainmem_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[ADDR_W+1:2]);
   endfunction

   // Issue one request and follow it to completion. Inputs other than access
   // are scrambled right after acceptance to show the request was latched.
   task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input int hold, input bit drop,
                         output int bcnt, output int dcnt, output logic done_at_fall,
                         output logic [31:0] rd_at_fall);
      mainmem_access = 1'b1;
      re = r; we = w; addr = a; reg_data = d;
      step();
      if (drop) mainmem_access = 1'b0;
      re = 1'($urandom); we = 1'($urandom);
      addr = $urandom; reg_data = $urandom;
      bcnt = 0;
      dcnt = 0;
      while (mainmem_busy && bcnt < 64) begin
         bcnt++;
         if (mainmem_done) dcnt++;
         step();
      end
      done_at_fall = mainmem_done;
      if (mainmem_done) dcnt++;
      rd_at_fall = dram_data;
      for (int i = 0; i < hold; i++) begin
         step();
         chk("held_busy", 32'(mainmem_busy), 32'd0);
         chk("held_done", 32'(mainmem_done), 32'd0);
      end
      mainmem_access = 1'b0;
      step();
   endtask

   // Run a request and compare against the model's expectation.
   task automatic run_check(input string tag, input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] d,
                            input int hold, input bit drop);
      int          bcnt, dcnt, exp_busy;
      logic        dfall;
      logic [31:0] rd, exp_rd;
      if (w) begin
         exp_busy = WRITE_LAT;
         exp_rd   = last_rd;
         mem_m[idx_of(a)] = d;
      end else begin
         exp_busy = READ_LAT;
         exp_rd   = mem_m[idx_of(a)];
         last_rd  = exp_rd;
      end
      do_req(w, r, a, d, hold, drop, bcnt, dcnt, dfall, rd);
      chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
      chk({tag, "_done_pulse"}, 32'(dfall), 32'd1);
      chk({tag, "_done_count"}, 32'(dcnt), 32'd1);
      chk({tag, "_dram_data"}, rd, exp_rd);
   endtask

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      int          exp_busy;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int          bcnt, dcnt;
      logic        dfall;
      logic [31:0] rd;

      tbl[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, WRITE_LAT, 32'h0000_0000};
      tbl[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         READ_LAT,  32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, WRITE_LAT, 32'hDEAD_BEEF};
      tbl[3] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         READ_LAT,  32'h1234_5678};
      tbl[4] = '{1'b1, 1'b0, 32'h0000_1004, 32'hA5A5_A5A5, WRITE_LAT, 32'h1234_5678};
      tbl[5] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         READ_LAT,  32'hA5A5_A5A5};
      tbl[6] = '{1'b0, 1'b1, 32'hFFFF_F010, 32'h0,         READ_LAT,  32'hDEAD_BEEF};

      rst = 1'b0;
      mainmem_access = 1'b1; we = 1'b1; re = 1'b0;
      addr = 32'h0000_0040; reg_data = 32'hFFFF_FFFF;
      last_rd = 32'h0;

      // Reset held two cycles with a write request present
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_busy", 32'(mainmem_busy), 32'd0);
         chk("rst_done", 32'(mainmem_done), 32'd0);
         chk("rst_dram", dram_data, 32'd0);
      end
      mainmem_access = 1'b0;
      rst = 1'b1;
      step();

      // Access without qualifiers is ignored
      mainmem_access = 1'b1; re = 1'b0; we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("noqual_busy", 32'(mainmem_busy), 32'd0);
      end
      mainmem_access = 1'b0;
      step();

      // Directed table
      for (int i = 0; i < 7; i++) begin
         do_req(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, 0, 1'b0, bcnt, dcnt, dfall, rd);
         chk($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 32'(tbl[i].exp_busy));
         chk($sformatf("tbl%0d_done_pulse", i), 32'(dfall), 32'd1);
         chk($sformatf("tbl%0d_dram_data", i), rd, tbl[i].exp_rd);
         if (tbl[i].w) mem_m[idx_of(tbl[i].a)] = tbl[i].d;
         else last_rd = tbl[i].exp_rd;
      end

      // Held access after a read: stays done, no re-accept
      run_check("held", 1'b0, 1'b1, 32'h0000_0010, 32'h0, 5, 1'b0);
      // Access dropped during service still completes
      run_check("drop", 1'b1, 1'b0, 32'h0000_0050, 32'h0F0F_0F0F, 0, 1'b1);
      run_check("dropr", 1'b0, 1'b1, 32'h0000_0050, 32'h0, 0, 1'b1);

      // Reset in the second busy cycle of a write to 0x30
      run_check("pre30", 1'b1, 1'b0, 32'h0000_0030, 32'h0BAD_F00D, 0, 1'b0);
      mainmem_access = 1'b1; we = 1'b1; re = 1'b0;
      addr = 32'h0000_0030; reg_data = 32'h1111_1111;
      step();
      chk("mid_busy1", 32'(mainmem_busy), 32'd1);
      step();
      chk("mid_busy2", 32'(mainmem_busy), 32'd1);
      rst = 1'b0;
      step();
      chk("mid_rst_busy", 32'(mainmem_busy), 32'd0);
      chk("mid_rst_done", 32'(mainmem_done), 32'd0);
      chk("mid_rst_dram", dram_data, 32'd0);
      rst = 1'b1;
      mainmem_access = 1'b0;
      last_rd = 32'h0;
      step();
      run_check("post30", 1'b0, 1'b1, 32'h0000_0030, 32'h0, 0, 1'b0);

      // Randomized traffic over a small index set with aliasing upper bits
      for (int n = 0; n < 40; n++) begin
         logic        w, r;
         logic [31:0] a, d;
         int          ix;
         ix = int'($urandom_range(0, 15));
         a  = {$urandom_range(0, 32'h000F_FFFF) , 12'h0} | 32'(ix << 2) | 32'($urandom_range(0, 3));
         d  = $urandom;
         w  = 1'($urandom);
         r  = w ? 1'($urandom) : 1'b1;
         if (!w && !mem_m.exists(idx_of(a))) begin
            w = 1'b1;
            r = 1'b0;
         end
         run_check($sformatf("rnd%0d", n), w, r, a, d,
                   int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
